// File: rtl/rsa_avm_wrapper.sv
// Avalon-MM master: polls the UART, loads the RSA key and ciphertext MSB-first,
// launches the modexp core and streams the plaintext back through UART TX.
module rsa_avm_wrapper #(
    parameter int BITS        = 256,
    parameter int RX_BASE     = 0,
    parameter int TX_BASE     = 4,
    parameter int STATUS_BASE = 8,
    parameter int RX_OK_BIT   = 7,
    parameter int TX_OK_BIT   = 6
) (
    input  logic            avm_clk,
    input  logic            avm_rst_n,
    output logic [4:0]      avm_address,
    output logic            avm_read,
    input  logic [31:0]     avm_readdata,
    output logic            avm_write,
    output logic [31:0]     avm_writedata,
    input  logic            avm_waitrequest,
    output logic            o_rsa_start,
    output logic [BITS-1:0] o_rsa_n,
    output logic [BITS-1:0] o_rsa_d,
    output logic [BITS-1:0] o_rsa_a,
    input  logic [BITS-1:0] i_rsa_result,
    input  logic            i_rsa_finished,
    output logic            o_led_idle
);

    localparam int BYTES = BITS / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CW-1:0] LAST_RX     = CW'(BYTES - 1);
    localparam logic [CW-1:0] LAST_TX     = CW'(BYTES - 2);
    localparam logic [4:0]    ADDR_RX     = 5'(RX_BASE);
    localparam logic [4:0]    ADDR_TX     = 5'(TX_BASE);
    localparam logic [4:0]    ADDR_STATUS = 5'(STATUS_BASE);

    typedef enum logic [2:0] {GET_N, GET_D, GET_A, CALC, SEND} state_t;
    typedef enum logic       {POLL, XFER} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   byteCnt_q, byteCnt_d;
    logic [BITS-1:0] keyN_q, keyN_d;
    logic [BITS-1:0] keyD_q, keyD_d;
    logic [BITS-1:0] cipher_q, cipher_d;
    logic [BITS-1:0] out_q, out_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [4:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            start_q, start_d;
    logic            ledIdle_q, ledIdle_d;

    logic       rdDone;
    logic       wrDone;
    logic [7:0] rxByte;
    logic       unusedReadBits;

    assign rdDone         = read_q && !avm_waitrequest;
    assign wrDone         = write_q && !avm_waitrequest;
    assign rxByte         = avm_readdata[7:0];
    assign unusedReadBits = ^avm_readdata;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        byteCnt_d = byteCnt_q;
        keyN_d    = keyN_q;
        keyD_d    = keyD_q;
        cipher_d  = cipher_q;
        out_d     = out_q;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        start_d   = 1'b0;

        case (state_q)
            GET_N, GET_D, GET_A: begin
                if (rdDone) begin
                    if (phase_q == POLL) begin
                        if (avm_readdata[RX_OK_BIT]) begin
                            phase_d = XFER;
                            addr_d  = ADDR_RX;
                        end
                    end else begin
                        if (state_q == GET_N) begin
                            keyN_d = {keyN_q[BITS-9:0], rxByte};
                        end else if (state_q == GET_D) begin
                            keyD_d = {keyD_q[BITS-9:0], rxByte};
                        end else begin
                            cipher_d = {cipher_q[BITS-9:0], rxByte};
                        end
                        phase_d = POLL;
                        addr_d  = ADDR_STATUS;
                        if (byteCnt_q == LAST_RX) begin
                            byteCnt_d = '0;
                            if (state_q == GET_N) begin
                                state_d = GET_D;
                            end else if (state_q == GET_D) begin
                                state_d = GET_A;
                            end else begin
                                // Bus goes quiet while the core crunches the block.
                                state_d = CALC;
                                read_d  = 1'b0;
                                start_d = 1'b1;
                            end
                        end else begin
                            byteCnt_d = byteCnt_q + 1'b1;
                        end
                    end
                end
            end

            CALC: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (i_rsa_finished) begin
                    out_d     = i_rsa_result;
                    state_d   = SEND;
                    phase_d   = POLL;
                    read_d    = 1'b1;
                    addr_d    = ADDR_STATUS;
                    byteCnt_d = '0;
                end
            end

            SEND: begin
                if (phase_q == POLL) begin
                    if (rdDone && avm_readdata[TX_OK_BIT]) begin
                        phase_d = XFER;
                        read_d  = 1'b0;
                        write_d = 1'b1;
                        addr_d  = ADDR_TX;
                        // The top result byte is always zero, so transmission starts one byte down.
                        wdata_d = {24'b0, out_q[BITS-9 -: 8]};
                    end
                end else if (wrDone) begin
                    out_d   = out_q << 8;
                    phase_d = POLL;
                    write_d = 1'b0;
                    read_d  = 1'b1;
                    addr_d  = ADDR_STATUS;
                    if (byteCnt_q == LAST_TX) begin
                        byteCnt_d = '0;
                        state_d   = GET_A;
                    end else begin
                        byteCnt_d = byteCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d   = GET_N;
                phase_d   = POLL;
                byteCnt_d = '0;
                read_d    = 1'b1;
                write_d   = 1'b0;
                addr_d    = ADDR_STATUS;
            end
        endcase

        ledIdle_d = ((state_d == GET_N) || (state_d == GET_A)) && (byteCnt_d == '0);
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_q   <= GET_N;
            phase_q   <= POLL;
            byteCnt_q <= '0;
            keyN_q    <= '0;
            keyD_q    <= '0;
            cipher_q  <= '0;
            out_q     <= '0;
            read_q    <= 1'b1;
            write_q   <= 1'b0;
            addr_q    <= ADDR_STATUS;
            wdata_q   <= '0;
            start_q   <= 1'b0;
            ledIdle_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            byteCnt_q <= byteCnt_d;
            keyN_q    <= keyN_d;
            keyD_q    <= keyD_d;
            cipher_q  <= cipher_d;
            out_q     <= out_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            start_q   <= start_d;
            ledIdle_q <= ledIdle_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign o_rsa_start   = start_q;
    assign o_rsa_n       = keyN_q;
    assign o_rsa_d       = keyD_q;
    assign o_rsa_a       = cipher_q;
    assign o_led_idle    = ledIdle_q;

endmodule

// File: doc/rsa_avm_wrapper.md
Name: rsa_avm_wrapper

Overview:
- Avalon-MM master inside the RSA Qsys system, between the on-chip RS-232 UART slave and the RSA modular-exponentiation core.
- Polls the UART, assembles the key (N, d) and ciphertext blocks from the byte stream, and launches the core.
- Streams the plaintext back through the UART TX.
- Drives the LED_IDLE export that lights LEDG[0]/LEDR[0] on the board.

Parameters:
- BITS, 256, RSA operand width in bits; must be a multiple of 8.
- BYTES, BITS/8, bytes per operand (derived, not overridable).
- RX_BASE, 0, UART RX data register byte address.
- TX_BASE, 4, UART TX data register byte address.
- STATUS_BASE, 8, UART status register byte address.
- RX_OK_BIT, 7, status bit set when an RX byte is available.
- TX_OK_BIT, 6, status bit set when TX can accept a byte.

Ports:
- avm_clk  in  1  system clock (50 MHz)
- avm_rst_n  in  1  asynchronous active-low reset
- avm_address  out  5  Avalon byte address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data
- avm_waitrequest  in  1  slave stall
- o_rsa_start  out  1  one-cycle core start pulse
- o_rsa_n  out  BITS  modulus
- o_rsa_d  out  BITS  private exponent
- o_rsa_a  out  BITS  ciphertext
- i_rsa_result  in  BITS  a^d mod n
- i_rsa_finished  in  1  core done pulse
- o_led_idle  out  1  high while waiting for the first byte of a new ciphertext block

Behaviour:
- Reset values (async, avm_rst_n low):
  - avm_read=1, avm_address=STATUS_BASE, avm_write=0, avm_writedata=0
  - o_rsa_start=0, n/d/a=0, byte_cnt=0
  - main state GET_N, bus phase POLL
- Main FSM: GET_N -> GET_D -> GET_A -> CALC -> SEND -> GET_A (loops forever; the key is retained across blocks).
- Bus phases within GET_*/SEND:
  - POLL: read STATUS_BASE.
  - XFER: RX read at RX_BASE, or TX write at TX_BASE.
- Avalon rules:
  - read/write and address held stable while avm_waitrequest=1.
  - A transaction completes on the first cycle where the request is high and waitrequest=0; readdata is sampled on that cycle.
  - read and write are never asserted together.
- POLL completion:
  - In GET_*: if readdata[RX_OK_BIT]=1, go to XFER and issue read at RX_BASE on the next cycle. Otherwise re-issue the status read.
  - In SEND: if readdata[TX_OK_BIT]=1, go to XFER and issue write at TX_BASE. Otherwise re-poll.
- RX XFER completion:
  - target <= {target[BITS-9:0], readdata[7:0]} (MSB-first).
  - byte_cnt increments.
  - At byte_cnt=BYTES-1 the counter resets to 0 and the main state advances.
  - Return to POLL.
- GET_A -> CALC:
  - o_rsa_start pulses high exactly one cycle (the cycle after the last A byte lands).
  - o_rsa_a is stable from that cycle until the next GET_A byte.
- CALC:
  - No bus requests (read=0, write=0).
  - Waits for i_rsa_finished. On it, latch i_rsa_result into the output shift register, enter SEND, byte_cnt=0.
  - i_rsa_finished outside CALC is ignored.
- SEND:
  - Transmits BYTES-1 bytes: result bits [BITS-9:BITS-16] first, down to [7:0]. The top byte is always zero and is skipped.
  - writedata = {24'b0, out_reg[BITS-9:BITS-16]}.
  - After each write completes: out_reg <<= 8, byte_cnt increments.
  - After byte BYTES-2 completes: byte_cnt=0, go to GET_A.
- o_led_idle = 1 iff (state==GET_A && byte_cnt==0) || (state==GET_N && byte_cnt==0); registered, 0 out of reset for one cycle is acceptable.
  - Reset value is 0.
  - Drops the cycle after the first data byte is accepted.
- Width rules:
  - Address is a 5-bit byte address.
  - byte_cnt is $clog2(BYTES) bits; no wrap beyond BYTES-1.
- Reset mid-operation: everything returns to reset values, including the key. A partial transaction is abandoned and the slave is not waited on.
- Waitrequest asserted for arbitrarily many cycles must not lose or duplicate bytes.

Test Plan:
- Reset then idle UART (status readdata=0):
  - Wrapper re-reads STATUS_BASE continuously and never reads RX_BASE or writes.
  - o_led_idle=1 after the first cycle.
- Key load: feed 32 bytes 0x00..0x1F as N, then 32 bytes 0xFF as d:
  - o_rsa_n=0x000102..1F and o_rsa_d = all ones.
  - Exactly 64 RX reads, 0 writes.
- Full block with mock core (result=0x00 followed by 31 bytes 0xA5..):
  - After 32 A bytes, o_rsa_start high for exactly 1 cycle.
  - On finished, exactly 31 TX writes of the result bytes in MSB-first order.
  - FSM returns to GET_A with o_led_idle=1.
- Randomised waitrequest (0-7 stall cycles) and TX_OK low for 20 polls:
  - Byte streams are identical to the no-stall run.
  - Address and control are stable during stalls.
- Two consecutive ciphertext blocks without resending key: second decrypt uses the original N/d; second start pulse occurs after the 32nd byte of block two.
- avm_rst_n low while in SEND at byte 10, then released:
  - All outputs return to reset values and the state is GET_N.
  - No further TX writes until a new key and block are received.
